// File: rtl/pipe_dmem_ctrl.sv
// rtl/pipe_dmem_ctrl.sv - MEM-stage data-memory req/ack sequencer with pipeline stall
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module pipe_dmem_ctrl #(
  parameter int TO_CYCLES = 255,
  parameter int TO_W      = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic        mwreg,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] mmo,
  output logic        mwreg_o,
  output logic        stall,
  output logic        fault
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        acc;
  logic [31:0] rdata_q;
  logic        to_hit;
  logic        to_done;

  assign acc = mwmem | mm2reg;
  assign mmo = rdata_q;

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_q;
  logic            fault_q;

  // Fires on the ACCESS cycle in which the counter would reach TO_CYCLES; an ack that cycle wins.
  assign to_hit = (state == S_ACCESS) && !dm_ack && (to_cnt == TO_W'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      to_cnt  <= '0;
      to_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        to_cnt <= '0;
      end else if (state == S_ACCESS && !dm_ack) begin
        to_cnt <= to_cnt + 1'b1;
      end
      to_q <= to_hit;
      if (to_hit) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign to_done = to_q;
  assign fault   = fault_q;
`else
  assign to_hit  = 1'b0;
  assign to_done = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = acc ? S_ACCESS : S_IDLE;
      S_ACCESS: state_nxt = (dm_ack || to_hit) ? S_DONE : S_ACCESS;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    mwreg_o = 1'b0;
    case (state)
      S_IDLE: begin
        stall   = acc;
        mwreg_o = acc ? 1'b0 : mwreg;
      end
      S_ACCESS: begin
        stall   = 1'b1;
        mwreg_o = 1'b0;
      end
      S_DONE: begin
        stall   = 1'b0;
        mwreg_o = mwreg & ~to_done;
      end
      default: begin
        stall   = 1'b0;
        mwreg_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= S_IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      rdata_q  <= '0;
    end else begin
      state  <= state_nxt;
      // Request is high exactly for the ACCESS cycles; store wins when both controls are set.
      dm_req <= (state_nxt == S_ACCESS);
      dm_we  <= (state_nxt == S_ACCESS) && mwmem;
      if (state == S_IDLE && acc) begin
        dm_addr  <= malu;
        dm_wdata <= mb;
      end
      if (state == S_ACCESS && dm_ack && !mwmem) begin
        rdata_q <= dm_rdata;
      end else if (to_hit) begin
        rdata_q <= 32'hDEADBEEF;
      end
    end
  end

endmodule

// File: tb/tb_pipe_dmem_ctrl.sv
// tb/tb_pipe_dmem_ctrl.sv - directed self-checking bench for pipe_dmem_ctrl
module tb_pipe_dmem_ctrl;

  logic        clk;
  logic        clrn;
  logic        mwmem;
  logic        mm2reg;
  logic        mwreg;
  logic [31:0] malu;
  logic [31:0] mb;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic [31:0] mmo;
  logic        mwreg_o;
  logic        stall;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_dmem_ctrl #(.TO_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .clrn(clrn), .mwmem(mwmem), .mm2reg(mm2reg), .mwreg(mwreg),
    .malu(malu), .mb(mb), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mmo(mmo),
    .mwreg_o(mwreg_o), .stall(stall), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    mwmem = 0; mm2reg = 0; mwreg = 0; dm_ack = 0;
  endtask

  initial begin
    clrn = 0; mwmem = 0; mm2reg = 0; mwreg = 0; malu = 0; mb = 0;
    dm_rdata = 0; dm_ack = 0;
    #12;
    chk("rst_req", {31'd0, dm_req}, 0);
    chk("rst_we", {31'd0, dm_we}, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_mmo", mmo, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    clrn = 1;
    tick();

    // Load acked in the first ACCESS cycle
    mm2reg = 1; mwreg = 1; malu = 32'h0000_0100; settle();
    chk("ld1_idle_stall", {31'd0, stall}, 1);
    chk("ld1_idle_mwreg_o", {31'd0, mwreg_o}, 0);
    chk("ld1_idle_req", {31'd0, dm_req}, 0);
    tick();
    dm_ack = 1; dm_rdata = 32'h1234_5678; settle();
    chk("ld1_acc_stall", {31'd0, stall}, 1);
    chk("ld1_acc_req", {31'd0, dm_req}, 1);
    chk("ld1_acc_we", {31'd0, dm_we}, 0);
    chk("ld1_acc_addr", dm_addr, 32'h0000_0100);
    tick();
    dm_ack = 0; settle();
    chk("ld1_done_stall", {31'd0, stall}, 0);
    chk("ld1_done_req", {31'd0, dm_req}, 0);
    chk("ld1_done_mmo", mmo, 32'h1234_5678);
    chk("ld1_done_mwreg_o", {31'd0, mwreg_o}, 1);
    tick();

    // Store acked in the third ACCESS cycle
    idle_inputs(); mwmem = 1; malu = 32'h40; mb = 32'hA5A5_A5A5; settle();
    chk("st_idle_stall", {31'd0, stall}, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) dm_ack = 1;
      dm_rdata = 32'hFFFF_0000;
      settle();
      chk($sformatf("st_acc%0d_req", i), {31'd0, dm_req}, 1);
      chk($sformatf("st_acc%0d_we", i), {31'd0, dm_we}, 1);
      chk($sformatf("st_acc%0d_wdata", i), dm_wdata, 32'hA5A5_A5A5);
      chk($sformatf("st_acc%0d_addr", i), dm_addr, 32'h40);
      chk($sformatf("st_acc%0d_stall", i), {31'd0, stall}, 1);
      chk($sformatf("st_acc%0d_mwreg_o", i), {31'd0, mwreg_o}, 0);
    end
    tick();
    dm_ack = 0; settle();
    chk("st_done_stall", {31'd0, stall}, 0);
    chk("st_done_mwreg_o", {31'd0, mwreg_o}, 0);
    chk("st_done_mmo_kept", mmo, 32'h1234_5678);
    tick();

    // Two back-to-back loads
    idle_inputs(); mm2reg = 1; mwreg = 1; malu = 32'h200; settle();
    tick();
    dm_ack = 1; dm_rdata = 32'hCAFE_0001; settle();
    chk("bb1_acc_addr", dm_addr, 32'h200);
    tick();
    dm_ack = 0; settle();
    chk("bb1_done_mmo", mmo, 32'hCAFE_0001);
    chk("bb1_done_stall", {31'd0, stall}, 0);
    tick();
    malu = 32'h204; settle();
    chk("bb2_idle_stall", {31'd0, stall}, 1);
    chk("bb2_idle_req", {31'd0, dm_req}, 0);
    tick();
    dm_ack = 1; dm_rdata = 32'hCAFE_0002; settle();
    chk("bb2_acc_req", {31'd0, dm_req}, 1);
    chk("bb2_acc_addr", dm_addr, 32'h204);
    tick();
    dm_ack = 0; settle();
    chk("bb2_done_mmo", mmo, 32'hCAFE_0002);
    chk("bb2_done_mwreg_o", {31'd0, mwreg_o}, 1);
    tick();

    // Both load and store set: treated as store, mmo untouched
    idle_inputs(); mwmem = 1; mm2reg = 1; malu = 32'h300; mb = 32'h0F0F_0F0F; settle();
    tick();
    dm_ack = 1; dm_rdata = 32'h5555_5555; settle();
    chk("both_acc_we", {31'd0, dm_we}, 1);
    tick();
    dm_ack = 0; settle();
    chk("both_done_mmo", mmo, 32'hCAFE_0002);
    tick();

    // Non-memory instruction with a stray ack
    idle_inputs(); mwreg = 1; dm_ack = 1; dm_rdata = 32'h9999_9999; settle();
    chk("nm_stall", {31'd0, stall}, 0);
    chk("nm_mwreg_o", {31'd0, mwreg_o}, 1);
    tick();
    chk("nm_after_req", {31'd0, dm_req}, 0);
    chk("nm_after_stall", {31'd0, stall}, 0);
    chk("nm_after_mmo", mmo, 32'hCAFE_0002);
    dm_ack = 0;
    tick();

    // Reset asserted mid-ACCESS
    idle_inputs(); mm2reg = 1; mwreg = 1; malu = 32'h400; settle();
    tick();
    chk("rm_acc_req", {31'd0, dm_req}, 1);
    #2;
    clrn = 0; idle_inputs(); settle();
    chk("rm_req", {31'd0, dm_req}, 0);
    chk("rm_mmo", mmo, 0);
    chk("rm_fault", {31'd0, fault}, 0);
    chk("rm_stall", {31'd0, stall}, 0);
    tick();
    clrn = 1;
    tick();
    mm2reg = 1; mwreg = 1; malu = 32'h404; settle();
    tick();
    dm_ack = 1; dm_rdata = 32'h7777_0000; settle();
    chk("rm_new_addr", dm_addr, 32'h404);
    tick();
    dm_ack = 0; settle();
    chk("rm_new_mmo", mmo, 32'h7777_0000);
    chk("rm_new_mwreg_o", {31'd0, mwreg_o}, 1);
    tick();
    idle_inputs();

`ifdef MEM_TIMEOUT_EN
    // Load never acked: times out after 4 ACCESS cycles
    mm2reg = 1; mwreg = 1; malu = 32'h500; settle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_acc%0d_stall", i), {31'd0, stall}, 1);
      chk($sformatf("to_acc%0d_req", i), {31'd0, dm_req}, 1);
    end
    tick();
    chk("to_done_stall", {31'd0, stall}, 0);
    chk("to_done_mmo", mmo, 32'hDEADBEEF);
    chk("to_done_fault", {31'd0, fault}, 1);
    chk("to_done_mwreg_o", {31'd0, mwreg_o}, 0);
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    chk("to_sticky_fault", {31'd0, fault}, 1);
    clrn = 0; settle();
    chk("to_rst_fault", {31'd0, fault}, 0);
    tick();
    clrn = 1;
    tick();

    // Ack on the 4th ACCESS cycle wins over the timeout
    mm2reg = 1; mwreg = 1; malu = 32'h600; settle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) begin
        dm_ack = 1; dm_rdata = 32'h4444_0004;
      end
      settle();
      chk($sformatf("ta_acc%0d_stall", i), {31'd0, stall}, 1);
    end
    tick();
    dm_ack = 0; settle();
    chk("ta_done_mmo", mmo, 32'h4444_0004);
    chk("ta_done_fault", {31'd0, fault}, 0);
    chk("ta_done_mwreg_o", {31'd0, mwreg_o}, 1);
    tick();
    idle_inputs();
`else
    // Without the timeout feature, an unacked access simply waits
    mm2reg = 1; mwreg = 1; malu = 32'h500; settle();
    for (int i = 0; i < 8; i++) tick();
    chk("nto_wait_stall", {31'd0, stall}, 1);
    chk("nto_wait_fault", {31'd0, fault}, 0);
    dm_ack = 1; dm_rdata = 32'h8888_0008; settle();
    tick();
    dm_ack = 0; settle();
    chk("nto_done_mmo", mmo, 32'h8888_0008);
    chk("nto_done_stall", {31'd0, stall}, 0);
    tick();
    idle_inputs();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
